// File: rtl/bitfusion_pkg.sv
// Shared Bit Fusion types and helpers.
// Used by the operand feeder and the fusion top level.
package bitfusion_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STREAM,
        ST_DONE
    } bf_state_e;

    localparam logic [3:0] BF_W1 = 4'd1;
    localparam logic [3:0] BF_W2 = 4'd2;
    localparam logic [3:0] BF_W4 = 4'd4;
    localparam logic [3:0] BF_W8 = 4'd8;

    function automatic logic bf_width_legal(input logic [3:0] w);
        return (w == BF_W1) || (w == BF_W2) ||
               (w == BF_W4) || (w == BF_W8);
    endfunction

endpackage

// File: rtl/bf_word_slicer.sv
// Load/shift register emitting one lane per beat, LSB lane first.
// Shifting zero-fills, so the lane reads 0 once a word is drained.
module bf_word_slicer
    import bitfusion_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [LANE_W-1:0] byte_o
);

    logic [WORD_W-1:0] sh_q;

    // Load a fresh word, otherwise drain one lane per beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else if (load_i) begin
            sh_q <= word_i;
        end else if (shift_i) begin
            sh_q <= sh_q >> LANE_W;
        end
    end

    assign byte_o = sh_q[LANE_W-1:0];

endmodule

// File: rtl/bitfusion_operand_feeder.sv
// Serialises packed act/wgt word pairs into 8-bit operand beats.
// Prefetches on the last beat of a word to keep the stream gap-free.
module bitfusion_operand_feeder
    import bitfusion_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        cfg_in_width,
    input  logic [3:0]        cfg_weight_width,
    input  logic              cfg_s_in,
    input  logic              cfg_s_weight,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [WORD_W-1:0] src_act,
    input  logic [WORD_W-1:0] src_wgt,
    output logic [LANE_W-1:0] in,
    output logic [LANE_W-1:0] weight,
    output logic [3:0]        in_width,
    output logic [3:0]        weight_width,
    output logic              s_in,
    output logic              s_weight,
    output logic              op_valid,
    output logic              op_last,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int BEATS = WORD_W / LANE_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    bf_state_e        state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [LEN_W-1:0] left_q, left_d;
    logic             cfg_ok, go, last_beat, hs, ld, sh;
    logic             valid_q, last_q, busy_q, done_q, err_q;
    logic [3:0]       iw_q, ww_q;
    logic             si_q, sw_q;

    assign cfg_ok = bf_width_legal(cfg_in_width) &&
                    bf_width_legal(cfg_weight_width) &&
                    (cfg_len != '0);
    assign go        = (state_q == ST_IDLE) && start;
    assign last_beat = (beat_q == LAST_BEAT);
    assign hs        = src_ready && src_valid;

    // Ready is a pure state decode so it never waits on src_valid
    always_comb begin
        src_ready = 1'b0;
        unique case (state_q)
            ST_FETCH:  src_ready = 1'b1;
            ST_STREAM: src_ready = last_beat && (left_q != '0);
            default:   src_ready = 1'b0;
        endcase
    end

    // Next state, beat counter, remaining words and slicer controls
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        left_d  = left_q;
        ld      = 1'b0;
        sh      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (go && cfg_ok) begin
                    state_d = ST_FETCH;
                    left_d  = cfg_len;
                end
            end
            ST_FETCH: begin
                if (hs) begin
                    ld      = 1'b1;
                    left_d  = left_q - LEN_W'(1);
                    beat_d  = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                sh = 1'b1;
                if (!last_beat) begin
                    beat_d = beat_q + BW'(1);
                end else if (left_q == '0) begin
                    state_d = ST_DONE;
                end else if (hs) begin
                    ld     = 1'b1;
                    left_d = left_q - LEN_W'(1);
                    beat_d = '0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            left_q  <= left_d;
        end
    end

    // Status outputs registered from the next-state view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= (state_d == ST_STREAM);
            last_q  <= (state_d == ST_STREAM) &&
                       (beat_d == LAST_BEAT) && (left_d == '0);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            err_q   <= go && !cfg_ok;
        end
    end

    // Configuration is only replaced by a legal launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iw_q <= '0;
            ww_q <= '0;
            si_q <= 1'b0;
            sw_q <= 1'b0;
        end else if (go && cfg_ok) begin
            iw_q <= cfg_in_width;
            ww_q <= cfg_weight_width;
            si_q <= cfg_s_in;
            sw_q <= cfg_s_weight;
        end
    end

    bf_word_slicer #(.WORD_W(WORD_W)) u_act (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ld),
        .shift_i (sh),
        .word_i  (src_act),
        .byte_o  (in)
    );

    bf_word_slicer #(.WORD_W(WORD_W)) u_wgt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (ld),
        .shift_i (sh),
        .word_i  (src_wgt),
        .byte_o  (weight)
    );

    assign in_width     = iw_q;
    assign weight_width = ww_q;
    assign s_in         = si_q;
    assign s_weight     = sw_q;
    assign op_valid     = valid_q;
    assign op_last      = last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = err_q;

endmodule

// File: tb/tb_bitfusion_operand_feeder.sv
// Bench for the Bit Fusion operand feeder.
// Configuration table, directed corner sequences and random runs.
module tb_bitfusion_operand_feeder;

    localparam int WORD_W = 32;
    localparam int LEN_W  = 8;
    localparam int BEATS  = WORD_W / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        cfg_in_width = '0;
    logic [3:0]        cfg_weight_width = '0;
    logic              cfg_s_in = 1'b0;
    logic              cfg_s_weight = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              src_valid = 1'b0;
    logic              src_ready;
    logic [WORD_W-1:0] src_act = '0;
    logic [WORD_W-1:0] src_wgt = '0;
    logic [7:0]        in, weight;
    logic [3:0]        in_width, weight_width;
    logic              s_in, s_weight, op_valid, op_last;
    logic              busy, done, cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] e_iw = '0, e_ww = '0;
    logic       e_si = 1'b0, e_sw = 1'b0;

    logic [WORD_W-1:0] q_act[$];
    logic [WORD_W-1:0] q_wgt[$];
    int                q_idle[$];

    typedef struct {
        logic [3:0] iw;
        logic [3:0] ww;
        logic       si;
        logic       sw;
        int         len;
        bit         err;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    bitfusion_operand_feeder #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .cfg_in_width     (cfg_in_width),
        .cfg_weight_width (cfg_weight_width),
        .cfg_s_in         (cfg_s_in),
        .cfg_s_weight     (cfg_s_weight),
        .cfg_len          (cfg_len),
        .src_valid        (src_valid),
        .src_ready        (src_ready),
        .src_act          (src_act),
        .src_wgt          (src_wgt),
        .in               (in),
        .weight           (weight),
        .in_width         (in_width),
        .weight_width     (weight_width),
        .s_in             (s_in),
        .s_weight         (s_weight),
        .op_valid         (op_valid),
        .op_last          (op_last),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_cfg(input string name);
        chk(name, 32'({in_width, weight_width, s_in, s_weight}),
            32'({e_iw, e_ww, e_si, e_sw}));
    endtask

    task automatic chk_zero(input string name);
        chk(name, 32'({in, weight, in_width, weight_width, s_in, s_weight,
                       op_valid, op_last, busy, done, cfg_err, src_ready}),
            32'(0));
    endtask

    function automatic bit legal_w(input logic [3:0] w);
        return (w == 4'd1) || (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
    endfunction

    task automatic build(input int len, input int idle_max);
        q_act.delete();
        q_wgt.delete();
        q_idle.delete();
        for (int i = 0; i < len; i++) begin
            q_act.push_back($urandom);
            q_wgt.push_back($urandom);
            q_idle.push_back(i == 0 ? 0 : int'($urandom_range(0, idle_max)));
        end
    endtask

    // Source: idle gaps measured from the previous accepted word
    task automatic feed();
        for (int i = 0; i < q_act.size(); i++) begin
            for (int k = 0; k < q_idle[i]; k++) begin
                @(negedge clk);
                src_valid = 1'b0;
                src_act   = $urandom;
                src_wgt   = $urandom;
            end
            @(negedge clk);
            src_valid = 1'b1;
            src_act   = q_act[i];
            src_wgt   = q_wgt[i];
            for (int g = 0; g < 200 && !src_ready; g++) @(negedge clk);
        end
        @(negedge clk);
        src_valid = 1'b0;
        src_act   = $urandom;
        src_wgt   = $urandom;
    endtask

    task automatic poke_start();
        for (int g = 0; g < 100 && !op_valid; g++) @(negedge clk);
        @(negedge clk);
        cfg_in_width     = (e_iw == 4'd8) ? 4'd1 : 4'd8;
        cfg_weight_width = (e_ww == 4'd8) ? 4'd2 : 4'd8;
        cfg_s_in         = ~e_si;
        cfg_s_weight     = ~e_sw;
        cfg_len          = 8'd5;
        start            = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference: bytes of each queued word LSB first, one per beat
    task automatic watch(output int bubbles, output int nbeats);
        int total;
        int cyc;
        int last_cyc;
        int w;
        int b;
        bit fin;
        total    = q_act.size() * BEATS;
        cyc      = 0;
        last_cyc = -100;
        fin      = 1'b0;
        bubbles  = 0;
        nbeats   = 0;
        while (!fin && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (op_valid) begin
                w = nbeats / BEATS;
                b = nbeats % BEATS;
                if (nbeats < total) begin
                    chk("beat_in", 32'(in), 32'(q_act[w][8*b +: 8]));
                    chk("beat_wgt", 32'(weight), 32'(q_wgt[w][8*b +: 8]));
                    chk("op_last", 32'(op_last), 32'(nbeats == total - 1));
                    chk("beat_ready", 32'(src_ready),
                        32'((b == BEATS - 1) && (w < q_act.size() - 1)));
                end else begin
                    chk("extra_beat", 32'(nbeats), 32'(total - 1));
                end
                chk_cfg("cfg_hold");
                nbeats++;
                last_cyc = cyc;
            end else begin
                chk("idle_zero", 32'({in, weight}), 32'(0));
                if (nbeats > 0 && nbeats < total) bubbles++;
                if (!done) chk("fetch_ready", 32'(src_ready), 32'(1));
            end
            chk("busy", 32'(busy), 32'(1));
            chk("no_err", 32'(cfg_err), 32'(0));
            if (done) begin
                fin = 1'b1;
                chk("done_after_last", 32'(cyc - last_cyc), 32'(1));
                chk("beat_count", 32'(nbeats), 32'(total));
                chk("done_ready", 32'(src_ready), 32'(0));
            end
        end
        if (!fin) chk("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic run(input logic [3:0] iw, input logic [3:0] ww,
                       input logic si, input logic sw, input bit do_poke);
        int bub;
        int nb;
        int exp_bub;
        @(negedge clk);
        cfg_in_width     = iw;
        cfg_weight_width = ww;
        cfg_s_in         = si;
        cfg_s_weight     = sw;
        cfg_len          = LEN_W'(q_act.size());
        start            = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e_iw  = iw;
        e_ww  = ww;
        e_si  = si;
        e_sw  = sw;
        chk("start_busy", 32'(busy), 32'(1));
        chk("start_ready", 32'(src_ready), 32'(1));
        chk_cfg("start_cfg");
        exp_bub = 0;
        for (int i = 1; i < q_idle.size(); i++)
            if (q_idle[i] > BEATS - 1) exp_bub += q_idle[i] - (BEATS - 1);
        fork
            feed();
            watch(bub, nb);
            if (do_poke) poke_start();
        join
        chk("bubbles", 32'(bub), 32'(exp_bub));
        @(posedge clk);
        #1;
        chk("post_busy", 32'(busy), 32'(0));
        chk("post_done", 32'(done), 32'(0));
        chk("post_ready", 32'(src_ready), 32'(0));
        chk_cfg("post_cfg");
    endtask

    task automatic bad_start(input logic [3:0] iw, input logic [3:0] ww,
                             input int len);
        @(negedge clk);
        cfg_in_width     = iw;
        cfg_weight_width = ww;
        cfg_s_in         = $urandom;
        cfg_s_weight     = $urandom;
        cfg_len          = LEN_W'(len);
        start            = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 32'(cfg_err), 32'(1));
        chk("err_busy", 32'(busy), 32'(0));
        chk("err_ready", 32'(src_ready), 32'(0));
        chk_cfg("err_cfg_kept");
        @(negedge clk);
        chk("err_clear", 32'(cfg_err), 32'(0));
        chk("err_busy2", 32'(busy), 32'(0));
        chk("err_ready2", 32'(src_ready), 32'(0));
    endtask

    task automatic single_word();
        q_act.delete();
        q_wgt.delete();
        q_idle.delete();
        q_act.push_back(32'h4433_2211);
        q_wgt.push_back(32'h8877_6655);
        q_idle.push_back(0);
    endtask

    initial begin
        logic [3:0] wl[4];
        logic [3:0] a;
        logic [3:0] c;
        wl = '{4'd1, 4'd2, 4'd4, 4'd8};

        tbl[0] = '{iw: 4'd8,  ww: 4'd8, si: 1'b0, sw: 1'b0, len: 1, err: 1'b0};
        tbl[1] = '{iw: 4'd3,  ww: 4'd8, si: 1'b0, sw: 1'b0, len: 2, err: 1'b1};
        tbl[2] = '{iw: 4'd4,  ww: 4'd4, si: 1'b1, sw: 1'b0, len: 0, err: 1'b1};
        tbl[3] = '{iw: 4'd1,  ww: 4'd2, si: 1'b0, sw: 1'b1, len: 2, err: 1'b0};
        tbl[4] = '{iw: 4'd0,  ww: 4'd4, si: 1'b1, sw: 1'b1, len: 1, err: 1'b1};
        tbl[5] = '{iw: 4'd8,  ww: 4'd15, si: 1'b0, sw: 1'b0, len: 1, err: 1'b1};
        tbl[6] = '{iw: 4'd2,  ww: 4'd4, si: 1'b1, sw: 1'b1, len: 3, err: 1'b0};
        tbl[7] = '{iw: 4'd5,  ww: 4'd2, si: 1'b0, sw: 1'b1, len: 2, err: 1'b1};
        tbl[8] = '{iw: 4'd4,  ww: 4'd8, si: 1'b1, sw: 1'b0, len: 6, err: 1'b0};

        #2 rst_n = 1'b0;
        #1;
        chk_zero("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("after_reset");

        // Single word, no stall: 11/55 22/66 33/77 44/88
        single_word();
        run(4'd8, 4'd8, 1'b0, 1'b0, 1'b0);

        // Back-to-back, three words with src_valid always ready
        build(3, 0);
        run(4'd8, 4'd8, 1'b0, 1'b0, 1'b0);

        // Source stall before word 2 opens a gap of five beats
        build(2, 0);
        q_idle[1] = 8;
        run(4'd4, 4'd4, 1'b0, 1'b1, 1'b0);

        // Configuration table
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].err) begin
                bad_start(tbl[i].iw, tbl[i].ww, tbl[i].len);
            end else begin
                build(tbl[i].len, 5);
                run(tbl[i].iw, tbl[i].ww, tbl[i].si, tbl[i].sw, 1'b0);
            end
        end

        // Reset on beat 2 of word 1
        single_word();
        @(negedge clk);
        cfg_in_width     = 4'd8;
        cfg_weight_width = 4'd8;
        cfg_s_in         = 1'b1;
        cfg_s_weight     = 1'b1;
        cfg_len          = 8'd1;
        start            = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed();
        chk("rst_beat1", 32'({in, weight}), 32'(16'h1155));
        @(posedge clk);
        #1;
        chk("rst_beat2", 32'({in, weight}), 32'(16'h2266));
        #2 rst_n = 1'b0;
        #1;
        chk_zero("rst_midrun");
        e_iw = '0;
        e_ww = '0;
        e_si = 1'b0;
        e_sw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) rst_n = 1'b1;
            chk("rst_no_done", 32'({done, busy, op_valid}), 32'(0));
        end
        single_word();
        run(4'd8, 4'd8, 1'b0, 1'b0, 1'b0);

        // Start while busy: widths 2/4 signed must hold
        build(3, 2);
        run(4'd2, 4'd4, 1'b1, 1'b1, 1'b1);

        // Random runs against the byte-stream model
        for (int r = 0; r < 25; r++) begin
            build(int'($urandom_range(1, 5)), 7);
            run(wl[$urandom_range(0, 3)], wl[$urandom_range(0, 3)],
                $urandom, $urandom, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                a = 4'($urandom);
                c = 4'($urandom);
                if (legal_w(a) && legal_w(c))
                    bad_start(a, c, 0);
                else
                    bad_start(a, c, int'($urandom_range(0, 4)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
